// File: rtl/ysyx_22050535_rf_wb_arbiter.sv
// rtl/ysyx_22050535_rf_wb_arbiter.sv - round-robin register-file write-port arbiter with busy scoreboard
module ysyx_22050535_rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_NUM    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_addr,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  input  logic                  set_valid,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
  output logic                  hazard,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  // prio names the side that wins a tie: 0 = EXU, 1 = LSU
  logic                  prio_q, prio_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [REG_NUM-1:0]    busy_q, busy_d;
  logic                  exu_gnt;
  logic                  lsu_gnt;

  // Grant decode: a lone requester wins, a tie goes to the side named by prio
  always_comb begin
    exu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (!rst) begin
      exu_gnt = exu_valid && (!lsu_valid || !prio_q);
      lsu_gnt = lsu_valid && (!exu_valid ||  prio_q);
    end
  end

  assign exu_ready = exu_gnt;
  assign lsu_ready = lsu_gnt;

  // Masking with rst drops a write still sitting in the output register when reset hits
  assign rf_wen   = rf_wen_q & ~rst;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // No bypass: hazard looks only at the registered busy bits
  assign hazard = ~rst & (busy_q[chk_addr1] | busy_q[chk_addr2]);

  // Next write-port contents and pointer update; x0 grants handshake but never write
  always_comb begin
    prio_d     = prio_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (exu_gnt) begin
      prio_d     = 1'b1;
      rf_wen_d   = (exu_addr != '0);
      rf_waddr_d = exu_addr;
      rf_wdata_d = exu_data;
    end else if (lsu_gnt) begin
      prio_d     = 1'b0;
      rf_wen_d   = (lsu_addr != '0);
      rf_waddr_d = lsu_addr;
      rf_wdata_d = lsu_data;
    end
  end

  // Scoreboard: clear on the write cycle, then set so a new producer keeps ownership
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (set_valid && (set_addr != '0)) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      prio_q     <= prio_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050535_rf_wb_arbiter.sv
// tb/tb_ysyx_22050535_rf_wb_arbiter.sv - scoreboard bench for the register-file writeback arbiter
module tb_ysyx_22050535_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RN = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          exu_valid, lsu_valid, set_valid;
  logic [AW-1:0] exu_addr, lsu_addr, set_addr, chk_addr1, chk_addr2;
  logic [DW-1:0] exu_data, lsu_data;
  logic          exu_ready, lsu_ready, hazard, rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  ysyx_22050535_rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_NUM(RN)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_addr(exu_addr), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .set_valid(set_valid), .set_addr(set_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard(hazard),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int            tag;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Reference model state
  bit            busy_m[RN];
  bit            exu_won_last;
  bit            cur_w;
  logic [AW-1:0] cur_a;
  bit            hold_known, hold_now;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  int            exu_wait, lsu_wait;
  bit            exu_g_s, lsu_g_s;

  // Model: expected readies and hazard this cycle, then the state it predicts after the edge
  always @(negedge clk) begin
    bit            eg, lg;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    exu_g_s = exu_ready;
    lsu_g_s = lsu_ready;
    if (rst) begin
      chk("exu_ready_in_rst", 32'(exu_ready), 32'd0);
      chk("lsu_ready_in_rst", 32'(lsu_ready), 32'd0);
      chk("hazard_in_rst", 32'(hazard), 32'd0);
      for (int i = 0; i < RN; i++) busy_m[i] = 1'b0;
      exu_won_last = 1'b0;
      cur_w        = 1'b0;
      hold_known   = 1'b1;
      hold_a       = '0;
      hold_d       = '0;
      hold_now     = 1'b1;
      exu_wait     = 0;
      lsu_wait     = 0;
    end else begin
      if (hold_now && hold_known) begin
        chk("rf_waddr_hold", 32'(rf_waddr), 32'(hold_a));
        chk("rf_wdata_hold", rf_wdata, hold_d);
      end
      // Tie goes to whichever side did not win the previous arbitration
      eg = exu_valid && (!lsu_valid || !exu_won_last);
      lg = lsu_valid && (!exu_valid ||  exu_won_last);
      chk("exu_ready", 32'(exu_ready), 32'(eg));
      chk("lsu_ready", 32'(lsu_ready), 32'(lg));
      chk("hazard", 32'(hazard), 32'(busy_m[chk_addr1] | busy_m[chk_addr2]));
      exu_wait = (exu_valid && !exu_ready) ? exu_wait + 1 : 0;
      lsu_wait = (lsu_valid && !lsu_ready) ? lsu_wait + 1 : 0;
      chk("exu_wait_bound", 32'(exu_wait <= 1), 32'd1);
      chk("lsu_wait_bound", 32'(lsu_wait <= 1), 32'd1);
      ga = eg ? exu_addr : lsu_addr;
      gd = eg ? exu_data : lsu_data;
      if (cur_w) busy_m[cur_a] = 1'b0;
      if (set_valid && set_addr != 0) busy_m[set_addr] = 1'b1;
      cur_w    = 1'b0;
      hold_now = !(eg || lg);
      if (eg || lg) begin
        exu_won_last = eg;
        if (ga != 0) begin
          exp_q.push_back('{tag: cyc + 1, addr: ga, data: gd});
          cur_w      = 1'b1;
          cur_a      = ga;
          hold_known = 1'b1;
          hold_a     = ga;
          hold_d     = gd;
        end else begin
          hold_known = 1'b0;
        end
      end
    end
  end

  // Monitor: every cycle the write port must match the queued expectation, if any
  always @(negedge clk) begin
    wr_t e;
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      e = exp_q.pop_front();
      if (rst) begin
        chk("rf_wen_discard_on_rst", 32'(rf_wen), 32'd0);
      end else begin
        chk("rf_wen", 32'(rf_wen), 32'd1);
        chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
        chk("rf_wdata", rf_wdata, e.data);
      end
    end else begin
      chk("rf_wen_idle", 32'(rf_wen), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exu_valid = 1'b0; lsu_valid = 1'b0; set_valid = 1'b0;
    exu_addr = '0; lsu_addr = '0; set_addr = '0;
    exu_data = '0; lsu_data = '0;
    chk_addr1 = '0; chk_addr2 = '0;
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, RN - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    // EXU alone
    exu_valid = 1'b1; exu_addr = 5'd5; exu_data = 32'h1234;
    tick();
    exu_valid = 1'b0;
    tick();
    // LSU alone, leaving EXU to win the next tie
    lsu_valid = 1'b1; lsu_addr = 5'd6; lsu_data = 32'h66;
    tick();
    lsu_valid = 1'b0;
    tick();
    // Contention: EXU 10, LSU 20, EXU 11, LSU 21, then EXU 12 alone
    exu_valid = 1'b1; exu_addr = 5'd10; exu_data = 32'hA0;
    lsu_valid = 1'b1; lsu_addr = 5'd20; lsu_data = 32'hB0;
    tick();
    exu_addr = 5'd11; exu_data = 32'hA1;
    tick();
    lsu_addr = 5'd21; lsu_data = 32'hB1;
    tick();
    exu_addr = 5'd12; exu_data = 32'hA2;
    tick();
    lsu_valid = 1'b0;
    tick();
    exu_valid = 1'b0;
    tick();
    // Scoreboard on x7
    set_valid = 1'b1; set_addr = 5'd7; chk_addr1 = 5'd7;
    tick();
    set_valid = 1'b0;
    lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h77;
    tick();
    lsu_valid = 1'b0;
    tick();
    tick();
    // Writes and claims on x0
    exu_valid = 1'b1; exu_addr = 5'd0; exu_data = 32'hDEAD;
    set_valid = 1'b1; set_addr = 5'd0; chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    tick();
    exu_valid = 1'b0; set_valid = 1'b0;
    tick();
    // Set and clear of x3 at the same edge
    exu_valid = 1'b1; exu_addr = 5'd3; exu_data = 32'h33;
    set_valid = 1'b1; set_addr = 5'd3;
    tick();
    exu_valid = 1'b0;
    tick();
    set_valid = 1'b0; chk_addr1 = 5'd3;
    tick();
    tick();
    // Reset while a write is pending in the output register
    exu_valid = 1'b1; exu_addr = 5'd9; exu_data = 32'h99;
    tick();
    exu_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    // Randomized traffic; requesters hold until granted
    for (int i = 0; i < 3000; i++) begin
      if (!exu_valid || exu_g_s) begin
        exu_valid = ($urandom_range(0, 99) < 60);
        exu_addr  = pick();
        exu_data  = $urandom;
      end
      if (!lsu_valid || lsu_g_s) begin
        lsu_valid = ($urandom_range(0, 99) < 60);
        lsu_addr  = pick();
        lsu_data  = $urandom;
      end
      set_valid = ($urandom_range(0, 99) < 30);
      set_addr  = pick();
      chk_addr1 = pick();
      chk_addr2 = pick();
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick(); tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
